// File: rtl/weight_bram_seq_ctrl.sv
// Sequencer/arbiter for one single-port weight BRAM shared by a bulk loader
// and an in-order, back-pressured read sweep that feeds one neuron MAC.
module weight_bram_seq_ctrl #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          LD_START,
  input  logic          LD_VALID,
  input  logic [DW-1:0] LD_DATA,
  output logic          LD_READY,
  output logic          LD_DONE,
  input  logic          START,
  output logic          W_VALID,
  output logic [DW-1:0] W_DATA,
  output logic [AW-1:0] W_INDEX,
  output logic          W_LAST,
  input  logic          W_READY,
  output logic          DONE,
  output logic          BUSY,
  output logic [AW-1:0] BR_ADDR,
  output logic [DW-1:0] BR_DI,
  output logic          BR_EN,
  output logic          BR_WE,
  input  logic [DW-1:0] BR_DO
);

  typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} state_t;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_q;
  logic [AW-1:0] wcnt_q;
  logic [AW-1:0] rcnt_q;
  logic          pend_rd_q;
  logic          ld_done_q;
  logic          done_q;
  logic          rd_vld_q;
  logic [DW-1:0] rd_data_q;
  logic [AW-1:0] rd_idx_q;
  logic [DW-1:0] fifo_data_q [2];
  logic [AW-1:0] fifo_idx_q  [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    fcnt_q;
  logic [1:0]    fcnt_d;
  logic          ld_beat;
  logic          issue;
  logic          push;
  logic          pop;
  logic [2:0]    credit_used;

  assign LD_READY = (state_q == LOAD);
  assign LD_DONE  = ld_done_q;
  assign DONE     = done_q;
  assign BUSY     = (state_q != IDLE);
  assign W_VALID  = (fcnt_q != 2'd0);
  assign W_DATA   = fifo_data_q[rd_ptr_q];
  assign W_INDEX  = fifo_idx_q[rd_ptr_q];
  assign W_LAST   = W_VALID && (W_INDEX == LAST_ADDR);

  assign ld_beat = LD_READY && LD_VALID;
  assign push    = rd_vld_q;
  assign pop     = W_VALID && W_READY;
  assign fcnt_d  = fcnt_q + {1'b0, push} - {1'b0, pop};

  // Outstanding words are FIFO entries plus the read whose data sits in rd_data_q.
  assign credit_used = {1'b0, fcnt_q} + {2'b0, rd_vld_q} - {2'b0, pop};
  assign issue       = (state_q == READ) && (credit_used < 3'd2);

  // Gating with RST_N keeps an asserted reset from touching the BRAM at the falling edge.
  assign BR_EN   = RST_N && (ld_beat || issue);
  assign BR_WE   = RST_N && ld_beat;
  assign BR_ADDR = BR_WE ? wcnt_q : (BR_EN ? rcnt_q : '0);
  assign BR_DI   = BR_WE ? LD_DATA : '0;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      pend_rd_q <= 1'b0;
      ld_done_q <= 1'b0;
      done_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      rd_idx_q  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      fcnt_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
    end else begin
      ld_done_q <= 1'b0;
      done_q    <= 1'b0;
      rd_vld_q  <= issue;
      if (issue) begin
        rd_data_q <= BR_DO;
        rd_idx_q  <= rcnt_q;
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= rd_data_q;
        fifo_idx_q[wr_ptr_q]  <= rd_idx_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fcnt_q <= fcnt_d;

      unique case (state_q)
        IDLE: begin
          if (LD_START) begin
            state_q   <= LOAD;
            pend_rd_q <= START;
          end else if (START) begin
            state_q <= READ;
          end
        end
        LOAD: begin
          if (START) pend_rd_q <= 1'b1;
          if (ld_beat) begin
            if (wcnt_q == LAST_ADDR) begin
              wcnt_q    <= '0;
              ld_done_q <= 1'b1;
              pend_rd_q <= 1'b0;
              state_q   <= (pend_rd_q || START) ? READ : IDLE;
            end else begin
              wcnt_q <= wcnt_q + AW'(1);
            end
          end
        end
        READ: begin
          if (issue) begin
            if (rcnt_q == LAST_ADDR) begin
              rcnt_q  <= '0;
              state_q <= DRAIN;
            end else begin
              rcnt_q <= rcnt_q + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (pop && W_LAST) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_bram_seq_ctrl.sv
// Scoreboard bench for weight_bram_seq_ctrl over a behavioural falling-edge BRAM:
// load, full-rate sweep, backpressure, arbitration, reset abort and random ready.
module tb_weight_bram_seq_ctrl;

  localparam int DEPTH = 28;
  localparam int AW    = 5;
  localparam int DW    = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
  } expBeat_t;

  logic          CLK      = 1'b0;
  logic          RST_N    = 1'b0;
  logic          LD_START = 1'b0;
  logic          LD_VALID = 1'b0;
  logic [DW-1:0] LD_DATA  = '0;
  logic          START    = 1'b0;
  logic          W_READY  = 1'b0;
  logic          LD_READY;
  logic          LD_DONE;
  logic          W_VALID;
  logic [DW-1:0] W_DATA;
  logic [AW-1:0] W_INDEX;
  logic          W_LAST;
  logic          DONE;
  logic          BUSY;
  logic [AW-1:0] BR_ADDR;
  logic [DW-1:0] BR_DI;
  logic          BR_EN;
  logic          BR_WE;
  logic [DW-1:0] BR_DO;

  int            passCount  = 0;
  int            totalCount = 0;
  int            cyc        = 0;
  int            doneSeen   = 0;
  int            expDone    = 0;
  int            rdyMode    = 0;
  int            found;
  int            at;
  int            startCyc;
  int            doneBefore;
  logic          stallPrev  = 1'b0;
  logic          lastHsPrev = 1'b0;
  logic          monHsLast;
  expBeat_t      expQ[$];
  logic [DW-1:0] expMem [DEPTH];
  logic [DW-1:0] bramMem [32];
  logic [DW-1:0] bramDout;

  weight_bram_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .LD_START(LD_START), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA),
    .LD_READY(LD_READY), .LD_DONE(LD_DONE),
    .START(START), .W_VALID(W_VALID), .W_DATA(W_DATA), .W_INDEX(W_INDEX),
    .W_LAST(W_LAST), .W_READY(W_READY), .DONE(DONE), .BUSY(BUSY),
    .BR_ADDR(BR_ADDR), .BR_DI(BR_DI), .BR_EN(BR_EN), .BR_WE(BR_WE), .BR_DO(BR_DO)
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Single-port BRAM: both write and read happen on the falling edge.
  always @(negedge CLK) begin
    if (BR_EN) begin
      if (BR_WE) bramMem[BR_ADDR] <= BR_DI;
      else       bramDout <= bramMem[BR_ADDR];
    end
  end
  assign BR_DO = bramDout;

  initial forever begin
    @(posedge CLK);
    #1;
    case (rdyMode)
      0:       W_READY = 1'b1;
      1:       W_READY = 1'($urandom_range(0, 1));
      default: W_READY = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic ldStart, input logic st);
    @(posedge CLK);
    #1;
    LD_START = ldStart;
    START    = st;
    @(posedge CLK);
    #1;
    LD_START = 1'b0;
    START    = 1'b0;
  endtask

  task automatic pushSweep(input logic [DW-1:0] base, input logic useBase);
    expBeat_t b;
    for (int i = 0; i < DEPTH; i++) begin
      b.data = useBase ? base + DW'(i) : expMem[i];
      b.idx  = AW'(i);
      expQ.push_back(b);
    end
    expDone++;
  endtask

  task automatic startSweep();
    pushSweep('0, 1'b0);
    applyStimulus(1'b0, 1'b1);
  endtask

  task automatic waitDone(input int budget, output int doneAt);
    doneAt = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      if (DONE) begin
        doneAt = cyc;
        break;
      end
    end
    checkOutput("done_within_budget", 32'(doneAt >= 0), 32'd1);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_ld_ready", 32'(LD_READY), 0);
    checkOutput("rst_ld_done",  32'(LD_DONE),  0);
    checkOutput("rst_w_valid",  32'(W_VALID),  0);
    checkOutput("rst_w_last",   32'(W_LAST),   0);
    checkOutput("rst_done",     32'(DONE),     0);
    checkOutput("rst_busy",     32'(BUSY),     0);
    checkOutput("rst_br_en",    32'(BR_EN),    0);
    checkOutput("rst_br_we",    32'(BR_WE),    0);
    checkOutput("rst_br_addr",  32'(BR_ADDR),  0);
    checkOutput("rst_br_di",    32'(BR_DI),    0);
    checkOutput("rst_w_data",   32'(W_DATA),   0);
    checkOutput("rst_w_index",  32'(W_INDEX),  0);
  endtask

  task automatic loadWeights(input logic [DW-1:0] base, input logic withStart);
    if (withStart) pushSweep(base, 1'b1);
    applyStimulus(1'b1, withStart);
    LD_VALID = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      LD_DATA = base + DW'(i);
      @(negedge CLK);
      checkOutput("ld_ready", 32'(LD_READY), 1);
      checkOutput("ld_we",    32'(BR_WE),    1);
      checkOutput("ld_addr",  32'(BR_ADDR),  32'(i));
      checkOutput("ld_di",    32'(BR_DI),    32'(base + DW'(i)));
      @(posedge CLK);
      #1;
    end
    LD_VALID = 1'b0;
    @(negedge CLK);
    checkOutput("ld_done",         32'(LD_DONE),  1);
    checkOutput("ld_ready_after",  32'(LD_READY), 0);
    checkOutput("busy_after_load", 32'(BUSY),     32'(withStart));
    if (withStart) begin
      checkOutput("read_follows_en",   32'(BR_EN),   1);
      checkOutput("read_follows_we",   32'(BR_WE),   0);
      checkOutput("read_follows_addr", 32'(BR_ADDR), 0);
    end
    @(negedge CLK);
    checkOutput("ld_done_pulse", 32'(LD_DONE), 0);
    for (int i = 0; i < DEPTH; i++) expMem[i] = base + DW'(i);
  endtask

  // Monitor: compares the FIFO head against the scoreboard and pops on handshake.
  initial forever begin
    @(negedge CLK);
    if (!RST_N) begin
      stallPrev  = 1'b0;
      lastHsPrev = 1'b0;
    end else begin
      monHsLast = 1'b0;
      if (stallPrev) checkOutput("valid_held", 32'(W_VALID), 1);
      if (W_VALID) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_word", 32'(W_VALID), 0);
        end else begin
          checkOutput("w_data",  32'(W_DATA),  32'(expQ[0].data));
          checkOutput("w_index", 32'(W_INDEX), 32'(expQ[0].idx));
          checkOutput("w_last",  32'(W_LAST),  32'(expQ[0].idx == AW'(DEPTH - 1)));
          if (W_READY) begin
            monHsLast = (expQ[0].idx == AW'(DEPTH - 1));
            void'(expQ.pop_front());
          end
        end
      end
      if (DONE || lastHsPrev) checkOutput("done_after_last", 32'(DONE), 32'(lastHsPrev));
      if (DONE) begin
        doneSeen++;
        checkOutput("busy_with_done", 32'(BUSY), 0);
      end
      if (BR_EN) checkOutput("addr_range", 32'(BR_ADDR <= AW'(DEPTH - 1)), 1);
      if (BR_WE) checkOutput("we_only_in_load", 32'(LD_READY), 1);
      stallPrev  = W_VALID && !W_READY;
      lastHsPrev = monHsLast;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    rdyMode = 0;
    RST_N   = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkResetOutputs();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    loadWeights(16'h0100, 1'b0);

    // Full-rate sweep with latency and length checks.
    pushSweep('0, 1'b0);
    @(posedge CLK);
    #1;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(negedge CLK);
    checkOutput("busy_at_start", 32'(BUSY), 1);
    checkOutput("wvalid_t0", 32'(W_VALID), 0);
    startCyc = cyc;
    @(negedge CLK);
    checkOutput("wvalid_t1", 32'(W_VALID), 0);
    @(negedge CLK);
    checkOutput("wvalid_t2", 32'(W_VALID), 1);
    waitDone(200, at);
    checkOutput("sweep_cycles", 32'(at - startCyc), 32'd30);

    // Backpressure at index 10.
    startSweep();
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(negedge CLK);
      if (W_VALID && W_READY && W_INDEX == AW'(9)) found = 1;
    end
    checkOutput("reach_index9", 32'(found), 1);
    rdyMode = 2;
    repeat (3) @(negedge CLK);
    checkOutput("bp_br_en",  32'(BR_EN),   0);
    checkOutput("bp_data",   32'(W_DATA),  32'h010A);
    checkOutput("bp_index",  32'(W_INDEX), 32'd10);
    repeat (2) @(negedge CLK);
    rdyMode = 0;
    waitDone(200, at);

    // Simultaneous LD_START/START, then a START during READ that must be ignored.
    loadWeights(16'h0200, 1'b1);
    applyStimulus(1'b0, 1'b1);
    waitDone(300, at);
    repeat (4) @(negedge CLK);
    checkOutput("arb_idle_busy",  32'(BUSY),    0);
    checkOutput("arb_idle_valid", 32'(W_VALID), 0);

    // Reset in the middle of a sweep.
    startSweep();
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(negedge CLK);
      if (W_VALID && W_INDEX == AW'(15)) found = 1;
    end
    checkOutput("reach_index15", 32'(found), 1);
    doneBefore = doneSeen;
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    expQ.delete();
    expDone--;
    @(negedge CLK);
    checkResetOutputs();
    repeat (5) @(negedge CLK);
    checkOutput("no_done_after_abort", 32'(doneSeen), 32'(doneBefore));

    startSweep();
    waitDone(200, at);

    // Random consumer readiness.
    rdyMode = 1;
    for (int s = 0; s < 10; s++) begin
      startSweep();
      waitDone(400, at);
    end
    rdyMode = 0;

    repeat (3) @(negedge CLK);
    checkOutput("done_count",  32'(doneSeen),    32'(expDone));
    checkOutput("queue_empty", 32'(expQ.size()), 0);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
